// File: rtl/umi_tx_serializer.sv
// Serializes one full-width UMI packet onto a narrower link, lowest chunk first,
// with first/last/burst framing sidebands and a single-entry buffer.
module umi_tx_serializer #(
    parameter int UW = 256,
    parameter int IW = 64
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          umi_in_valid,
    input  logic [UW-1:0] umi_in_packet,
    input  logic          umi_in_burst,
    output logic          umi_in_ready,
    output logic          link_valid,
    output logic [IW-1:0] link_data,
    output logic          link_first,
    output logic          link_last,
    output logic          link_burst,
    input  logic          link_ready,
    output logic          tx_busy
);
    localparam int NCH = UW / IW;
    localparam int CW  = $clog2(NCH);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [UW-1:0]           buf_q, buf_d;
    logic                    burst_q, burst_d;
    logic [NCH-1:0][IW-1:0]  chunks;
    logic                    full, accept, advance;

    assign full         = (state_q == SEND);
    assign chunks       = buf_q;
    assign link_valid   = full;
    assign link_data    = chunks[cnt_q];
    assign link_first   = full & (cnt_q == '0);
    assign link_last    = full & (cnt_q == CW'(NCH - 1));
    assign link_burst   = burst_q;
    assign tx_busy      = full;
    // Combinational from link_ready so the next packet loads as the last chunk leaves.
    assign umi_in_ready = ~full | (link_last & link_ready);
    assign accept       = umi_in_valid & umi_in_ready;
    assign advance      = link_valid & link_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        burst_d = burst_q;
        if (advance) begin
            if (link_last) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
        end
        // A new packet overrides the completion of the previous one.
        if (accept) begin
            buf_d   = umi_in_packet;
            burst_d = umi_in_burst;
            cnt_d   = '0;
            state_d = SEND;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            burst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            burst_q <= burst_d;
        end
    end
endmodule

// File: tb/tb_umi_tx_serializer.sv
// Directed bench for umi_tx_serializer: framing, back-to-back, backpressure,
// burst tagging, async reset and IW=128/32 chunking.
module tb_umi_tx_serializer;
    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          in_valid = 1'b0;
    logic [255:0]  in_packet = '0;
    logic          in_burst = 1'b0;
    logic          in_ready;
    logic          lv, lf, ll, lb, busy;
    logic [63:0]   ld;
    logic          lr = 1'b1;

    logic          v128 = 1'b0, r128, lv128, lf128, ll128, lb128, lr128 = 1'b1, busy128;
    logic [127:0]  ld128;
    logic          v32 = 1'b0, r32, lv32, lf32, ll32, lb32, lr32 = 1'b1, busy32;
    logic [31:0]   ld32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    umi_tx_serializer #(.UW(256), .IW(64)) dut (
        .clk(clk), .nreset(nreset), .umi_in_valid(in_valid), .umi_in_packet(in_packet),
        .umi_in_burst(in_burst), .umi_in_ready(in_ready), .link_valid(lv), .link_data(ld),
        .link_first(lf), .link_last(ll), .link_burst(lb), .link_ready(lr), .tx_busy(busy));

    umi_tx_serializer #(.UW(256), .IW(128)) dut128 (
        .clk(clk), .nreset(nreset), .umi_in_valid(v128), .umi_in_packet(in_packet),
        .umi_in_burst(in_burst), .umi_in_ready(r128), .link_valid(lv128), .link_data(ld128),
        .link_first(lf128), .link_last(ll128), .link_burst(lb128), .link_ready(lr128), .tx_busy(busy128));

    umi_tx_serializer #(.UW(256), .IW(32)) dut32 (
        .clk(clk), .nreset(nreset), .umi_in_valid(v32), .umi_in_packet(in_packet),
        .umi_in_burst(in_burst), .umi_in_ready(r32), .link_valid(lv32), .link_data(ld32),
        .link_first(lf32), .link_last(ll32), .link_burst(lb32), .link_ready(lr32), .tx_busy(busy32));

    // Lane k of the test packets is the digit k repeated: 0x1111.. * k.
    function automatic logic [63:0] lane(input int k);
        return 64'h1111_1111_1111_1111 * 64'(k);
    endfunction

    function automatic logic [255:0] pkt(input int base);
        return {lane(base + 3), lane(base + 2), lane(base + 1), lane(base)};
    endfunction

    task automatic test_reset();
        #1;
        checks++; if (lv !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", lv); end
        checks++; if (lf !== 1'b0 || ll !== 1'b0) begin errors++; $display("FAIL reset_first_last got %b%b exp 00", lf, ll); end
        checks++; if (lb !== 1'b0) begin errors++; $display("FAIL reset_burst got %b exp 0", lb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        checks++; if (ld !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", ld); end
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        @(negedge clk);
        in_valid = 1'b1; in_packet = pkt(0); in_burst = 1'b0; lr = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (lv !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_valid k=%0d got %b/%b exp 1/1", k, lv, busy); end
            checks++; if (ld !== lane(k)) begin errors++; $display("FAIL single_data k=%0d got %h exp %h", k, ld, lane(k)); end
            checks++; if (lf !== (k == 0) || ll !== (k == 3)) begin errors++; $display("FAIL single_frame k=%0d got f%b l%b exp f%b l%b", k, lf, ll, k == 0, k == 3); end
            @(negedge clk);
        end
        #1;
        checks++; if (lv !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b/%b exp 0/0", lv, busy); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1; in_packet = pkt(0); lr = 1'b1;
        @(negedge clk);
        in_packet = pkt(4);
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (lv !== 1'b1) begin errors++; $display("FAIL b2b_valid k=%0d got %b exp 1", k, lv); end
            checks++; if (ld !== lane(k)) begin errors++; $display("FAIL b2b_data k=%0d got %h exp %h", k, ld, lane(k)); end
            checks++; if (lf !== (k % 4 == 0) || ll !== (k % 4 == 3)) begin errors++; $display("FAIL b2b_frame k=%0d got f%b l%b", k, lf, ll); end
            if (k < 4) begin
                checks++; if (in_ready !== (k == 3)) begin errors++; $display("FAIL b2b_ready k=%0d got %b exp %b", k, in_ready, k == 3); end
            end
            @(negedge clk);
            if (k == 3) in_valid = 1'b0;
        end
        #1;
        checks++; if (lv !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", lv); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1; in_packet = pkt(0); lr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (ld !== lane(0) || lf !== 1'b1) begin errors++; $display("FAIL bp_chunk0 got %h f%b exp %h f1", ld, lf, lane(0)); end
        @(negedge clk);
        lr = 1'b0; in_valid = 1'b1; in_packet = pkt(4);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (lv !== 1'b1 || ld !== lane(1)) begin errors++; $display("FAIL bp_hold c=%0d got v%b %h exp v1 %h", c, lv, ld, lane(1)); end
            checks++; if (lf !== 1'b0 || ll !== 1'b0) begin errors++; $display("FAIL bp_frame c=%0d got f%b l%b exp f0 l0", c, lf, ll); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c=%0d got %b exp 0", c, in_ready); end
            @(negedge clk);
        end
        lr = 1'b1; in_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            #1;
            checks++; if (ld !== lane(k) || ll !== (k == 3)) begin errors++; $display("FAIL bp_resume k=%0d got %h l%b exp %h l%b", k, ld, ll, lane(k), k == 3); end
            @(negedge clk);
        end
        #1;
        checks++; if (lv !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", lv); end
    endtask

    task automatic test_burst();
        @(negedge clk);
        in_valid = 1'b1; in_packet = pkt(0); in_burst = 1'b1; lr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_packet = '1; in_burst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (lb !== 1'b1 || ld !== lane(k)) begin errors++; $display("FAIL burst1 k=%0d got b%b %h exp b1 %h", k, lb, ld, lane(k)); end
            @(negedge clk);
        end
        in_valid = 1'b1; in_packet = pkt(4); in_burst = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_packet = '0; in_burst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (lb !== 1'b0 || ld !== lane(k + 4)) begin errors++; $display("FAIL burst0 k=%0d got b%b %h exp b0 %h", k, lb, ld, lane(k + 4)); end
            @(negedge clk);
        end
        in_burst = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_packet = pkt(0); lr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (ld !== lane(2) || lv !== 1'b1) begin errors++; $display("FAIL rst_pre got v%b %h exp v1 %h", lv, ld, lane(2)); end
        nreset = 1'b0;
        #1;
        checks++; if (lv !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async got v%b busy%b exp 0/0", lv, busy); end
        checks++; if (lf !== 1'b0 || ll !== 1'b0) begin errors++; $display("FAIL rst_frame got f%b l%b exp 00", lf, ll); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", in_ready); end
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_packet = pkt(4);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (ld !== lane(4) || lf !== 1'b1) begin errors++; $display("FAIL rst_restart got %h f%b exp %h f1", ld, lf, lane(4)); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [63:0] l;
        @(negedge clk);
        v128 = 1'b1; v32 = 1'b1; in_packet = pkt(0);
        @(negedge clk);
        v128 = 1'b0; v32 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k < 2) begin
                checks++; if (lv128 !== 1'b1 || ld128 !== {lane(2 * k + 1), lane(2 * k)}) begin errors++; $display("FAIL sw128_data k=%0d got v%b %h", k, lv128, ld128); end
                checks++; if (ll128 !== (k == 1) || lf128 !== (k == 0)) begin errors++; $display("FAIL sw128_frame k=%0d got f%b l%b", k, lf128, ll128); end
            end else if (k == 2) begin
                checks++; if (lv128 !== 1'b0) begin errors++; $display("FAIL sw128_idle got %b exp 0", lv128); end
            end
            l = lane(k / 2);
            checks++; if (lv32 !== 1'b1 || ld32 !== l[31:0]) begin errors++; $display("FAIL sw32_data k=%0d got v%b %h exp %h", k, lv32, ld32, l[31:0]); end
            checks++; if (ll32 !== (k == 7) || lf32 !== (k == 0)) begin errors++; $display("FAIL sw32_frame k=%0d got f%b l%b", k, lf32, ll32); end
            @(negedge clk);
        end
        #1;
        checks++; if (lv32 !== 1'b0) begin errors++; $display("FAIL sw32_idle got %b exp 0", lv32); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_burst();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/umi_tx_serializer.md
Name: umi_tx_serializer

Overview:
- Transmit-side stage directly downstream of the UMI packer.
- Accepts one full-width packed UMI packet per valid/ready handshake and serializes it onto a narrower physical link, lowest chunk first.
- Carries packet-framing sidebands (first/last chunk, burst continuation) so the receiving deserializer can rebuild packets.
- Single-entry buffered; zero-bubble back-to-back packets are sustained under no backpressure.

Parameters:
- UW, 256: packet width in bits; must be an integer multiple of IW.
- IW, 64: link data width in bits; UW/IW must be a power of two, at least 2.
- CW, $clog2(UW/IW): chunk counter width (derived; not overridden).

Ports:
- clk  input  1  core clock, all logic on rising edge.
- nreset  input  1  asynchronous active-low reset.
- umi_in_valid  input  1  packet valid.
- umi_in_packet  input  UW  packed packet from the packer.
- umi_in_burst  input  1  packet is a burst continuation (no command header).
- umi_in_ready  output  1  stage can accept a packet this cycle.
- link_valid  output  1  link chunk valid.
- link_data  output  IW  current chunk.
- link_first  output  1  chunk index 0 of a packet.
- link_last  output  1  chunk index UW/IW-1 of a packet.
- link_burst  output  1  registered umi_in_burst of the packet in flight, held for all chunks.
- link_ready  input  1  link accepts the chunk this cycle.
- tx_busy  output  1  a packet is held in the buffer.

Behaviour:
- Reset, asynchronous, while nreset=0:
  - full=0, cnt=0, link_valid=0, link_burst=0, packet buffer=0.
  - link_first and link_last are therefore 0, and umi_in_ready=1 (combinational, see below).
- Accept: when umi_in_valid & umi_in_ready, register umi_in_packet and umi_in_burst into the buffer, set full=1 and cnt=0.
- link_valid = full. link_data = buffer[cnt*IW +: IW]. link_first = full & (cnt==0). link_last = full & (cnt==UW/IW-1). tx_busy = full.
- Chunk advance: when link_valid & link_ready:
  - if not last, cnt increments by 1;
  - if last, the packet is complete and cnt returns to 0.
- umi_in_ready = ~full | (link_last & link_ready). This is a combinational path from link_ready, so a new packet loads in the same cycle the final chunk leaves.
- Simultaneous final-chunk accept and new input accept: buffer loads the new packet, full stays 1, cnt=0. The next cycle presents chunk 0 of the new packet with no idle cycle.
- Final-chunk accept with no new input: full=0 next cycle and link_valid drops.
- Backpressure: while link_valid=1 and link_ready=0, link_data, link_first, link_last, link_burst and cnt hold stable. A valid chunk is never withdrawn before it is accepted.
- umi_in_packet is sampled only on the accept edge; later changes to the input do not affect the packet in flight.
- Latency: a packet accepted at edge N presents chunk 0 after edge N. Minimum UW/IW cycles per packet; throughput is one chunk per cycle with link_ready held high.
- Reset mid-packet: the packet in flight is discarded with no partial completion; link_valid=0 immediately (asynchronously).
- umi_in_valid with umi_in_ready=0: no state change. The upstream must hold the packet.
- No other states: a 2-state machine IDLE(full=0)/SEND(full=1) with the cnt sub-counter. cnt wraps only through the last-chunk rule, never by arithmetic overflow.

Test Plan:
- Single packet, UW=256/IW=64, packet=0x3333..._2222..._1111..._0000... (each 64-bit lane a repeated digit), link_ready=1 -> 4 consecutive chunks 0x0000.., 0x1111.., 0x2222.., 0x3333..; link_first on chunk 0 only, link_last on chunk 3 only; link_valid low afterward; tx_busy high for exactly 4 cycles.
- Back-to-back: two packets offered continuously with link_ready=1 -> 8 consecutive valid chunks with no gap; umi_in_ready high in the cycle chunk 3 of packet A is accepted; packet B chunk 0 follows immediately.
- Backpressure: link_ready low for 3 cycles while chunk 1 is presented -> chunk 1 data, link_first=0, link_last=0 stable for all 3 cycles; umi_in_ready=0 throughout; cnt advances only once link_ready returns high.
- Burst tagging: packet with umi_in_burst=1, then packet with umi_in_burst=0; the input changes after the accept edge -> link_burst=1 on all 4 chunks of the first, 0 on all 4 of the second; link_data reflects the sampled values only.
- Reset mid-packet: assert nreset=0 during chunk 2 -> link_valid, link_first, link_last, tx_busy drop to 0 without waiting for a clock; after release umi_in_ready=1, and a new packet starts at chunk 0.
- Parameter sweep IW=128 and IW=32 with UW=256 -> 2 and 8 chunks respectively; link_last asserted at index 1 and 7; data order lowest chunk first.
